// File: rtl/spi_slave_in.sv
// spi_slave_in: mode-3 SPI receiver, LSB-first words presented on out_buf with a valid pulse.
module spi_slave_in #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sck,
  input  logic            cs,
  input  logic            mosi,
  output logic [BITS-1:0] out_buf,
  output logic            valid,
  output logic            frame_err,
  output logic            busy
);
  localparam int CW = $clog2(BITS);
  logic [2:0]      sck_q, cs_q;
  logic [1:0]      mosi_q;
  logic [BITS-1:0] sh_q, sh_d, out_buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_d, frame_err_d, busy_d;
  logic            sck_s, sck_p, cs_s, cs_p, mosi_s, rise, cs_fall, cs_rise, sample;
  assign sck_s   = sck_q[1];
  assign sck_p   = sck_q[2];
  assign cs_s    = cs_q[1];
  assign cs_p    = cs_q[2];
  assign mosi_s  = mosi_q[1];
  assign rise    = sck_s & ~sck_p;
  assign cs_fall = ~cs_s & cs_p;
  assign cs_rise = cs_s & ~cs_p;
  // cs_p keeps the final bit when cs rises alongside the last sck rise
  assign sample  = rise & ~cs_p;
  always_comb begin
    sh_d        = sample ? {mosi_s, sh_q[BITS-1:1]} : sh_q;
    cnt_d       = !sample ? cnt_q : (cnt_q == CW'(BITS-1)) ? '0 : cnt_q + CW'(1);
    valid_d     = sample && (cnt_q == CW'(BITS-1));
    out_buf_d   = valid_d ? sh_d : out_buf;
    cnt_d       = cs_fall ? '0 : cnt_d;
    frame_err_d = cs_rise && (cnt_d != '0);
    busy_d      = ~cs_s;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q     <= '1;
      cs_q      <= '1;
      mosi_q    <= '1;
      sh_q      <= '0;
      cnt_q     <= '0;
      out_buf   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sck_q     <= {sck_q[1:0], sck};
      cs_q      <= {cs_q[1:0], cs};
      mosi_q    <= {mosi_q[0], mosi};
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      out_buf   <= out_buf_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
      busy      <= busy_d;
    end
  end
endmodule

// File: tb/tb_spi_slave_in.sv
// tb_spi_slave_in: directed scenarios for spi_slave_in with BITS=4, mode-3 master emulated by tasks.
module tb_spi_slave_in;
  logic       clk = 0, reset = 1, sck = 1, cs = 1, mosi = 1;
  logic [3:0] out_buf;
  logic       valid, frame_err, busy;
  int         errors = 0, checks = 0;
  logic [3:0] vq[$];
  int         ferr_n = 0;

  spi_slave_in #(.BITS(4)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi),
    .out_buf(out_buf), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) vq.push_back(out_buf);
    if (frame_err) ferr_n++;
  end

  task automatic bit_send(input logic b);
    @(negedge clk);
    sck = 0;
    mosi = b;
    repeat (2) @(negedge clk);
    sck = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) bit_send(w[i]);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    cs = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_buf !== 4'h0) begin errors++; $display("FAIL reset_out_buf got %h want 0", out_buf); end
    checks++; if ({valid, frame_err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {valid, frame_err, busy}); end
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    checks++; if (vq.size() != 0 || ferr_n != 0 || busy !== 1'b0) begin errors++; $display("FAIL reset_release got v=%0d fe=%0d busy=%b want 0 0 0", vq.size(), ferr_n, busy); end
  endtask

  task automatic test_single_word();
    int base = vq.size(), fb = ferr_n;
    cs_low();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    send_bits(8'h0A, 4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_end got %b want 1", busy); end
    cs_high();
    checks++; if (vq.size() - base != 1) begin errors++; $display("FAIL single_count got %0d want 1", vq.size() - base); end
    else begin
      checks++; if (vq[base] !== 4'hA) begin errors++; $display("FAIL single_word got %h want a", vq[base]); end
    end
    checks++; if (ferr_n != fb || busy !== 1'b0) begin errors++; $display("FAIL single_ferr_busy got fe=%0d busy=%b want %0d 0", ferr_n, busy, fb); end
  endtask

  task automatic test_back_to_back();
    int base = vq.size(), fb = ferr_n;
    cs_low(); send_bits(8'h03, 4); cs_high();
    checks++; if (out_buf !== 4'h3) begin errors++; $display("FAIL b2b_hold got %h want 3", out_buf); end
    cs_low(); send_bits(8'h0C, 4); cs_high();
    checks++; if (vq.size() - base != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", vq.size() - base); end
    else begin
      checks++; if (vq[base] !== 4'h3 || vq[base+1] !== 4'hC) begin errors++; $display("FAIL b2b_words got %h %h want 3 c", vq[base], vq[base+1]); end
    end
    checks++; if (ferr_n != fb) begin errors++; $display("FAIL b2b_ferr got %0d want %0d", ferr_n, fb); end
  endtask

  task automatic test_short_frame();
    int base = vq.size(), fb = ferr_n;
    cs_low();
    send_bits(8'h03, 2);
    cs = 1;
    repeat (2) @(negedge clk);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_early got %b want 0", frame_err); end
    @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_pulse got %b want 1", frame_err); end
    @(negedge clk);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_width got %b want 0", frame_err); end
    repeat (4) @(negedge clk);
    checks++; if (vq.size() != base || out_buf !== 4'hC || ferr_n != fb + 1) begin errors++; $display("FAIL short_state got v=%0d out=%h fe=%0d want %0d c %0d", vq.size(), out_buf, ferr_n, base, fb + 1); end
    cs_low(); send_bits(8'h06, 4); cs_high();
    checks++; if (vq.size() != base + 1 || out_buf !== 4'h6) begin errors++; $display("FAIL short_recover got v=%0d out=%h want %0d 6", vq.size(), out_buf, base + 1); end
  endtask

  task automatic test_multi_word();
    int base = vq.size(), fb = ferr_n;
    cs_low(); send_bits(8'h5A, 8); cs_high();
    checks++; if (vq.size() - base != 2) begin errors++; $display("FAIL multi_count got %0d want 2", vq.size() - base); end
    else begin
      checks++; if (vq[base] !== 4'hA || vq[base+1] !== 4'h5) begin errors++; $display("FAIL multi_words got %h %h want a 5", vq[base], vq[base+1]); end
    end
    checks++; if (ferr_n != fb) begin errors++; $display("FAIL multi_ferr got %0d want %0d", ferr_n, fb); end
  endtask

  task automatic test_sck_idle();
    int base = vq.size(), fb = ferr_n;
    for (int i = 0; i < 4; i++) bit_send(i[0]);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    repeat (4) @(negedge clk);
    checks++; if (vq.size() != base || ferr_n != fb || out_buf !== 4'h5) begin errors++; $display("FAIL idle_state got v=%0d fe=%0d out=%h want %0d %0d 5", vq.size(), ferr_n, out_buf, base, fb); end
  endtask

  task automatic test_reset_mid_frame();
    int base, fb;
    cs_low();
    send_bits(8'h03, 2);
    reset = 1;
    #1;
    checks++; if ({out_buf, valid, frame_err, busy} !== 7'b0) begin errors++; $display("FAIL midrst_out got %h %b%b%b want 0 000", out_buf, valid, frame_err, busy); end
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (4) @(negedge clk);
    base = vq.size(); fb = ferr_n;
    send_bits(8'h05, 4);
    cs_high();
    checks++; if (vq.size() != base + 1 || out_buf !== 4'h5 || ferr_n != fb) begin errors++; $display("FAIL midrst_frame got v=%0d out=%h fe=%0d want %0d 5 %0d", vq.size(), out_buf, ferr_n, base + 1, fb); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_short_frame();
    test_multi_word();
    test_sck_idle();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave_in.md
# spi_slave_in

SPI slave receiver (input only) for the link driven by our SPI master transmitter. It synchronizes the `sck`, `cs` and `mosi` pins into the `clk` domain and samples `mosi` on each rising `sck` while `cs` is low. Bits are assembled LSB-first into a `BITS`-wide word, and each completed word is presented on `out_buf` with a one-cycle `valid` pulse. It sits on the chip's input side, feeding received setpoints and coefficients to the downstream control logic.

## Interface
- `BITS`, default 4: word width; legal range is `BITS >= 2`.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sck`  in  1  SPI clock from the master, asynchronous to `clk`; idles high.
- `cs`  in  1  chip select, active low, asynchronous; idles high.
- `mosi`  in  1  serial data, asynchronous; valid on rising `sck`.
- `out_buf`  out  `BITS`  last completed word; holds its value between words.
- `valid`  out  1  one-`clk` pulse when `out_buf` is updated.
- `frame_err`  out  1  one-`clk` pulse when `cs` rises mid-word.
- `busy`  out  1  high while the synchronized `cs` is low.

## Operation
- Protocol:
  - Mode 3: `sck` idles high, the master changes `mosi` on falling `sck`, and the slave samples on rising `sck`.
  - Bit 0 is sent first.
  - The master may raise `cs` in the same `clk` cycle as the final `sck` rise.
- Synchronizer:
  - Each of `sck`, `cs` and `mosi` passes through two flops, giving `sck_s`, `cs_s` and `mosi_s`.
  - `sck_s` and `cs_s` then feed one more delay flop each, giving `sck_p` and `cs_p`.
  - On reset, all synchronizer and delay flops load the idle value 1, so no edge is seen on reset release.
- Edge terms (all from synchronized signals):
  - `rise = sck_s & !sck_p`
  - `cs_fall = !cs_s & cs_p`
  - `cs_rise = cs_s & !cs_p`
- Sample condition: `rise & !cs_p`. Using `cs_p` rather than `cs_s` means the last bit is still captured when `cs` rises in the same cycle as the final `sck` rise.
- State:
  - Shift register `sh[BITS-1:0]`.
  - Bit counter `cnt`, width `$clog2(BITS)`, range 0..BITS-1.
- On sample:
  - `sh <= {mosi_s, sh[BITS-1:1]}`.
  - If `cnt == BITS-1`: `out_buf <= {mosi_s, sh[BITS-1:1]}`, `valid <= 1`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
- Continuous transfer: while `cs` stays low, the counter wraps and further bits form the next word. Multiple words per `cs` assertion are legal.
- On `cs_fall`: `cnt <= 0`. It takes priority over a sample in the same cycle, but a sample needs `!cs_p`, so the two cannot coincide.
- On `cs_rise`:
  - If `cnt != 0` after any same-cycle sample has been applied, `frame_err <= 1` and the partial word is discarded (`out_buf` is unchanged).
  - If `cnt == 0`, there is no error.
- Rising `sck` while `cs` is high is ignored: no shift, no count change.
- Outputs:
  - `valid` and `frame_err` are registered and default to 0 in every cycle they are not set.
  - `busy <= !cs_s`, registered.

## Timing
- Reset (asynchronous, takes effect immediately): `out_buf = 0`, `valid = 0`, `frame_err = 0`, `busy = 0`, `sh = 0`, `cnt = 0`, synchronizer flops = 1.
- Latency: a pin edge that is set up before `clk` edge k is detected between edges k+1 and k+2. The resulting `out_buf`, `valid` and `frame_err` updates are registered at edge k+2, so they are visible 3 `clk` edges after the pin change.
- Input constraints:
  - `sck` high and low phases must each be at least 2 `clk` periods.
  - `mosi` must be stable from the falling `sck` until at least 1 `clk` after the rising `sck`.
  - The master's `stb_level >= 1` satisfies both constraints.
- Throughput: at most one `valid` per `2*BITS*2` clk cycles at the minimum `sck` period.
- Reset released mid-frame: the synchronizers start from idle, so the still-low `cs` appears as a fresh `cs_fall`. The remaining bits form a partial word and end in `frame_err`, unless exactly `BITS` or a multiple of `BITS` bits remain.

## Test plan
- Single word: BITS=4, driven by `spi_master_out` with `stb_level = 2` and `in_buf = 4'b1010` → exactly one `valid` pulse, `out_buf = 4'hA`, `frame_err` never asserted, `busy` high for the duration of the frame.
- Back-to-back frames: master sends `4'h3`, then `4'hC` → two `valid` pulses with `out_buf` equal to 3 and then C; `out_buf` holds between the pulses.
- Short frame: hand-drive `cs` low, clock 2 bits, raise `cs` → one `frame_err` pulse 3 clk after the `cs` rise, no `valid`, `out_buf` keeps its prior value; a following 4-bit frame of `4'h6` gives `out_buf = 4'h6`.
- Multi-word under one `cs`: 8 bits LSB-first (`0x5A`) with `cs` held low → `valid` pulses with `4'hA` then `4'h5`, no `frame_err`.
- Reset mid-frame: assert `reset` after 2 bits → all outputs 0 in the same cycle; the next full frame of `4'h5` is received correctly.
- `sck` toggling for 8 edges while `cs` is high → no `valid`, no `frame_err`, `busy = 0`, `out_buf` unchanged.
